// File: rtl/pixel_pair_unpacker.sv
// Pops the bg/fg pixel FIFOs in lockstep and replays each wide entry
// as a stream of aligned (bg,fg) word pairs on a ready/valid port.
module pixel_pair_unpacker #(
    parameter int WORD_W    = 32,
    parameter int WORDS     = 4,
    parameter int LOW_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic                    clockgoing_pin,
    input  logic                    proc_sys_reset_0_Interconnect_aresetn_pin,
    input  logic [WORD_W*WORDS-1:0] bg_dout,
    input  logic                    bg_empty,
    output logic                    bg_rd_en,
    input  logic [WORD_W*WORDS-1:0] fg_dout,
    input  logic                    fg_empty,
    output logic                    fg_rd_en,
    output logic [WORD_W-1:0]       pair_bg,
    output logic [WORD_W-1:0]       pair_fg,
    output logic                    pair_valid,
    input  logic                    pair_ready,
    output logic                    pair_last,
    output logic [CNT_W-1:0]        entry_count
);
    localparam int E  = WORD_W * WORDS;
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, CAPT, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d, idx_nx;
    logic [E-1:0]      bg_buf_q, bg_buf_d;
    logic [E-1:0]      fg_buf_q, fg_buf_d;
    logic [WORD_W-1:0] pair_bg_q, pair_bg_d;
    logic [WORD_W-1:0] pair_fg_q, pair_fg_d;
    logic              pair_valid_q, pair_valid_d;
    logic              pair_last_q, pair_last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hs, at_last, pop;

    // Emission slot i maps to a physical word depending on LOW_FIRST.
    function automatic logic [WORD_W-1:0] word_at(
        input logic [E-1:0]  e,
        input logic [IW-1:0] i
    );
        logic [IW-1:0] w;
        w = (LOW_FIRST != 0) ? i : LAST_IDX - i;
        return e[w*WORD_W +: WORD_W];
    endfunction

    assign hs      = (state_q == DRAIN) & pair_ready;
    assign at_last = (idx_q == LAST_IDX);
    assign idx_nx  = idx_q + 1'b1;
    assign pop     = proc_sys_reset_0_Interconnect_aresetn_pin
                   & ~bg_empty & ~fg_empty
                   & ((state_q == IDLE) | (hs & at_last));

    assign bg_rd_en = pop;
    assign fg_rd_en = pop;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        bg_buf_d     = bg_buf_q;
        fg_buf_d     = fg_buf_q;
        pair_bg_d    = pair_bg_q;
        pair_fg_d    = pair_fg_q;
        pair_valid_d = pair_valid_q;
        pair_last_d  = pair_last_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pop) state_d = CAPT;
            end
            CAPT: begin
                bg_buf_d     = bg_dout;
                fg_buf_d     = fg_dout;
                idx_d        = '0;
                state_d      = DRAIN;
                pair_valid_d = 1'b1;
                pair_bg_d    = word_at(bg_dout, '0);
                pair_fg_d    = word_at(fg_dout, '0);
                pair_last_d  = 1'b0;
            end
            DRAIN: begin
                if (hs && !at_last) begin
                    idx_d       = idx_nx;
                    pair_bg_d   = word_at(bg_buf_q, idx_nx);
                    pair_fg_d   = word_at(fg_buf_q, idx_nx);
                    pair_last_d = (idx_nx == LAST_IDX);
                end else if (hs) begin
                    cnt_d        = cnt_q + 1'b1;
                    state_d      = pop ? CAPT : IDLE;
                    pair_valid_d = 1'b0;
                    pair_last_d  = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                pair_valid_d = 1'b0;
                pair_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clockgoing_pin
                or negedge proc_sys_reset_0_Interconnect_aresetn_pin) begin
        if (!proc_sys_reset_0_Interconnect_aresetn_pin) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            bg_buf_q     <= '0;
            fg_buf_q     <= '0;
            pair_bg_q    <= '0;
            pair_fg_q    <= '0;
            pair_valid_q <= 1'b0;
            pair_last_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            bg_buf_q     <= bg_buf_d;
            fg_buf_q     <= fg_buf_d;
            pair_bg_q    <= pair_bg_d;
            pair_fg_q    <= pair_fg_d;
            pair_valid_q <= pair_valid_d;
            pair_last_q  <= pair_last_d;
            cnt_q        <= cnt_d;
        end
    end

    assign pair_bg     = pair_bg_q;
    assign pair_fg     = pair_fg_q;
    assign pair_valid  = pair_valid_q;
    assign pair_last   = pair_last_q;
    assign entry_count = cnt_q;
endmodule
